// File: rtl/div_seq_pkg.sv
// Shared constants for the sequential divider: FSM encodings, iteration count, divide-by-zero quotient.
package div_seq_pkg;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ITER = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam int          DIV_STEPS  = 32;
   localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
endpackage

// File: rtl/div_seq_sub_cla_33.sv
// 33-bit subtractor a + ~b + 1 built from 4-bit carry-lookahead groups; bit 32 is the borrow/sign.
module sub_cla_33 (
   input  logic [32:0] a,
   input  logic [32:0] b,
   output logic [32:0] diff
);
   logic [31:0] g;
   logic [32:0] p;
   logic [32:0] c;

   assign g    = a[31:0] & ~b[31:0];
   assign p    = a ^ ~b;
   assign c[0] = 1'b1;

   for (genvar gi = 0; gi < 8; gi++) begin : grp
      localparam int B = gi * 4;
      assign c[B+1] = g[B] | (p[B] & c[B]);
      assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
      assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                    | (p[B+2] & p[B+1] & p[B] & c[B]);
      assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                    | (p[B+3] & p[B+2] & p[B+1] & g[B]) | ((&p[B+3:B]) & c[B]);
   end

   assign diff = p ^ c;
endmodule

// File: rtl/div_seq.sv
// Restoring signed 32-bit divider, one quotient bit per clock; quotient truncates toward zero,
// remainder follows the dividend sign. Results registered; start/busy/done handshake.
module div_seq
   import div_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);
   logic [1:0]       state;
   logic [WIDTH-1:0] p, a_reg, dvs;
   logic [4:0]       count;
   logic             sign_q, sign_r;

   logic [WIDTH:0]   p_shift, sub_a, sub_b, sub_y, neg_y;
   logic [WIDTH-1:0] dvd_abs, dvs_abs;

   // The trial subtractor doubles as the quotient negator in FIX.
   always_comb begin
      p_shift = {p, a_reg[WIDTH-1]};
      sub_a   = p_shift;
      sub_b   = {1'b0, dvs};
      if (state == S_FIX) begin
         sub_a = '0;
         sub_b = {1'b0, a_reg};
      end
      dvd_abs = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
      dvs_abs = divisor[WIDTH-1]  ? (~divisor  + 1'b1) : divisor;
   end

   sub_cla_33 u_sub (.a(sub_a), .b(sub_b), .diff(sub_y));
   sub_cla_33 u_neg (.a('0), .b({1'b0, p}), .diff(neg_y));

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state     <= S_IDLE;
         p         <= '0;
         a_reg     <= '0;
         dvs       <= '0;
         count     <= '0;
         sign_q    <= 1'b0;
         sign_r    <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         div_zero  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (divisor == '0) begin
                     quotient  <= DIV_ZERO_Q;
                     remainder <= dividend;
                     div_zero  <= 1'b1;
                     state     <= S_DONE;
                  end else begin
                     a_reg    <= dvd_abs;
                     dvs      <= dvs_abs;
                     sign_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                     sign_r   <= dividend[WIDTH-1];
                     p        <= '0;
                     count    <= '0;
                     div_zero <= 1'b0;
                     busy     <= 1'b1;
                     state    <= S_ITER;
                  end
               end
            end
            S_ITER: begin
               if (!sub_y[WIDTH]) begin
                  p     <= sub_y[WIDTH-1:0];
                  a_reg <= {a_reg[WIDTH-2:0], 1'b1};
               end else begin
                  p     <= p_shift[WIDTH-1:0];
                  a_reg <= {a_reg[WIDTH-2:0], 1'b0};
               end
               count <= count + 5'd1;
               if (count == 5'(DIV_STEPS - 1)) state <= S_FIX;
            end
            S_FIX: begin
               quotient  <= sign_q ? sub_y[WIDTH-1:0] : a_reg;
               // neg_y[WIDTH] is set only for a nonzero remainder; zero needs no negation.
               remainder <= (sign_r && neg_y[WIDTH]) ? neg_y[WIDTH-1:0] : p;
               state     <= S_DONE;
            end
            S_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
